// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and helpers for the multi-channel debouncer
package debounce_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_t;

    // Wide enough to hold STABLE_CNT itself; the counter never goes past it.
    function automatic int db_cnt_w(input int stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction

endpackage

// File: rtl/db_tick_gen.sv
// rtl/db_tick_gen.sv - sample-tick prescaler, one-cycle tick every TICK_DIV clocks
module db_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    // With TICK_DIV=1 the counter sits at 0 == LAST, so tick is constantly high.
    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel debouncer with edge pulses; DEBOUNCE_SYNC_EN adds a 2-flop input synchroniser
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   CHANNELS    = 4,
    parameter int   TICK_DIV    = 4,
    parameter int   STABLE_CNT  = 3,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] pb_in,
    output logic [CHANNELS-1:0] pb_level,
    output logic [CHANNELS-1:0] pb_rise,
    output logic [CHANNELS-1:0] pb_fall,
    output logic                pb_any
);

    localparam int            CW      = db_cnt_w(STABLE_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

    logic                w_tick;
    logic [CHANNELS-1:0] w_pb_s;

`ifdef DEBOUNCE_SYNC_EN
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= {CHANNELS{RESET_LEVEL}};
            r_sync2 <= {CHANNELS{RESET_LEVEL}};
        end else begin
            r_sync1 <= pb_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pb_s = r_sync2;
`else
    assign w_pb_s = pb_in;
`endif

    db_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        db_state_t     r_state;
        db_state_t     w_nxt_state;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_nxt_cnt;
        logic          r_level;
        logic          r_rise;
        logic          r_fall;
        logic          w_nxt_level;
        logic          w_nxt_rise;
        logic          w_nxt_fall;
        logic          w_diff;
        logic          w_accept;

        assign w_diff = (w_pb_s[g] != r_level);

        always_comb begin
            w_nxt_state = r_state;
            w_nxt_cnt   = r_cnt;
            w_nxt_level = r_level;
            w_nxt_rise  = 1'b0;
            w_nxt_fall  = 1'b0;
            w_accept    = 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_STABLE: begin
                        if (w_diff) begin
                            if (CNT_MAX == CW'(1)) begin
                                w_accept = 1'b1;
                            end else begin
                                w_nxt_state = ST_PENDING;
                                w_nxt_cnt   = CW'(1);
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (!w_diff) begin
                            w_nxt_state = ST_STABLE;
                            w_nxt_cnt   = '0;
                        end else if (r_cnt + CW'(1) == CNT_MAX) begin
                            w_accept = 1'b1;
                        end else begin
                            w_nxt_cnt = r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        w_nxt_state = ST_STABLE;
                        w_nxt_cnt   = '0;
                    end
                endcase
            end
            // Acceptance overrides whatever the state branch chose.
            if (w_accept) begin
                w_nxt_state = ST_STABLE;
                w_nxt_cnt   = '0;
                w_nxt_level = w_pb_s[g];
                w_nxt_rise  = w_pb_s[g];
                w_nxt_fall  = ~w_pb_s[g];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_level <= RESET_LEVEL;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_nxt_state;
                r_cnt   <= w_nxt_cnt;
                r_level <= w_nxt_level;
                r_rise  <= w_nxt_rise;
                r_fall  <= w_nxt_fall;
            end
        end

        assign pb_level[g] = r_level;
        assign pb_rise[g]  = r_rise;
        assign pb_fall[g]  = r_fall;
    end

    assign pb_any = |(pb_rise | pb_fall);

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - self-checking bench for debounce_multi against a run-length reference model
module tb_debounce_multi;

    localparam int   CH = 4;
    localparam int   TD = 4;
    localparam int   SC = 3;
    localparam logic RL = 1'b0;
`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT_LO = SYNC + (SC - 1) * TD + 1;
    localparam int LAT_HI = SYNC + (SC - 1) * TD + TD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] pb_in;
    logic [CH-1:0] pb_level;
    logic [CH-1:0] pb_rise;
    logic [CH-1:0] pb_fall;
    logic          pb_any;

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS    (CH),
        .TICK_DIV    (TD),
        .STABLE_CNT  (SC),
        .RESET_LEVEL (RL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pb_in    (pb_in),
        .pb_level (pb_level),
        .pb_rise  (pb_rise),
        .pb_fall  (pb_fall),
        .pb_any   (pb_any)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: count consecutive tick samples that differ from the level;
    // reaching SC accepts the sample. Tick phase is plain edge-count arithmetic.
    int            m_cyc;
    logic [CH-1:0] m_level;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    int            m_run [CH];
`ifdef DEBOUNCE_SYNC_EN
    logic [CH-1:0] m_q [$];
`endif

    function automatic void model_reset();
        m_cyc   = 0;
        m_level = {CH{RL}};
        m_rise  = '0;
        m_fall  = '0;
        foreach (m_run[i]) m_run[i] = 0;
`ifdef DEBOUNCE_SYNC_EN
        m_q = '{{CH{RL}}, {CH{RL}}};
`endif
    endfunction

    function automatic void model_edge(input logic [CH-1:0] v);
        logic [CH-1:0] s;
        bit            tick;
        if (!rst_n) begin
            model_reset();
            return;
        end
`ifdef DEBOUNCE_SYNC_EN
        s = m_q.pop_front();
        m_q.push_back(v);
`else
        s = v;
`endif
        tick   = ((m_cyc % TD) == TD - 1);
        m_cyc++;
        m_rise = '0;
        m_fall = '0;
        if (tick) begin
            for (int i = 0; i < CH; i++) begin
                if (s[i] != m_level[i]) m_run[i]++;
                else                    m_run[i] = 0;
                if (m_run[i] == SC) begin
                    m_level[i] = s[i];
                    m_run[i]   = 0;
                    if (s[i]) m_rise[i] = 1'b1;
                    else      m_fall[i] = 1'b1;
                end
            end
        end
    endfunction

    task automatic compare();
        check("level", pb_level, m_level);
        check("rise",  pb_rise,  m_rise);
        check("fall",  pb_fall,  m_fall);
        check("any",   pb_any,   |(m_rise | m_fall));
    endtask

    // Called at a negedge; drives v, lets one rising edge pass, checks at the next negedge.
    task automatic step(input logic [CH-1:0] v);
        pb_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        compare();
    endtask

    logic [CH-1:0] cur;

    task automatic press(input int ch, input bit chk_lo, input string tag);
        logic [CH-1:0] v;
        int            lat;
        int            np;
        v   = cur;
        v[ch] = ~v[ch];
        lat = 0;
        np  = 0;
        while (pb_level[ch] !== v[ch] && lat < 60) begin
            step(v);
            lat++;
            np += (pb_rise[ch] | pb_fall[ch]) ? 1 : 0;
        end
        check({tag, "_lat_hi"}, 32'(lat <= LAT_HI), 1);
        if (chk_lo) check({tag, "_lat_lo"}, 32'(lat >= LAT_LO), 1);
        repeat (20) begin
            step(v);
            np += (pb_rise[ch] | pb_fall[ch]) ? 1 : 0;
        end
        check({tag, "_pulses"}, np, 1);
        cur = v;
    endtask

    initial begin
        int lat;
        int np;
        int nany;
        int k;
        bit together;
        logic [CH-1:0] v;
        int hold_left [CH];

        rst_n = 1'b0;
        pb_in = '1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            compare();
        end

        // Release with all inputs high; first acceptance lands in the latency window.
        rst_n = 1'b1;
        lat = 0;
        while (pb_level !== '1 && lat < 60) begin
            step('1);
            lat++;
        end
        check("release_lat_lo", 32'(lat >= LAT_LO), 1);
        check("release_lat_hi", 32'(lat <= LAT_HI), 1);
        repeat (10) step('1);
        repeat (30) step('0);
        cur = '0;

        press(0, 1'b1, "clean_press");

        np = 0;
        for (int i = 0; i < 10; i++) begin
            cur[1] = ~cur[1];
            repeat (3) begin
                step(cur);
                np += pb_rise[1] ? 1 : 0;
            end
        end
        check("bounce_no_rise", np, 0);
        press(1, 1'b0, "bounce_settle");

        v = cur;
        v[2] = 1'b1;
        np = 0;
        repeat (5) begin
            step(v);
            np += (pb_rise[2] | pb_fall[2]) ? 1 : 0;
        end
        repeat (30) begin
            step(cur);
            np += (pb_rise[2] | pb_fall[2]) ? 1 : 0;
        end
        check("glitch_pulses", np, 0);
        check("glitch_level", pb_level[2], 0);

        v = cur;
        v[0] = 1'b0;
        v[3] = 1'b1;
        nany = 0;
        together = 1'b0;
        repeat (40) begin
            step(v);
            nany += pb_any ? 1 : 0;
            if (pb_fall[0] && pb_rise[3]) together = 1'b1;
        end
        check("simul_together", together, 1);
        check("simul_any_cycles", nany, 1);
        cur = v;

        v = cur;
        v[1] = ~v[1];
        k = 0;
        while (m_run[1] != 2 && k < 40) begin
            step(v);
            k++;
        end
        check("pending_reached", 32'(m_run[1] == 2), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_level", pb_level, {CH{RL}});
        check("rst_mid_pulse", {pb_rise, pb_fall, pb_any}, 0);
        model_reset();
        @(negedge clk);
        repeat (2) step(v);
        rst_n = 1'b1;
        cur = v;
        repeat (40) step(cur);

        foreach (hold_left[i]) hold_left[i] = $urandom_range(1, 20);
        repeat (2000) begin
            for (int i = 0; i < CH; i++) begin
                hold_left[i]--;
                if (hold_left[i] <= 0) begin
                    cur[i] = ~cur[i];
                    hold_left[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6)
                                                               : $urandom_range(10, 40);
                end
            end
            step(cur);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel push-button debouncer. It replaces the single-channel two-flop sampler with per-channel stability counters, a configurable sample-tick prescaler, and registered one-cycle rise/fall event pulses. It sits between raw board inputs (buttons, switches) and the control logic that consumes clean levels and edge events.

## Interface
- `CHANNELS`, 4: number of independent inputs, ≥1.
- `TICK_DIV`, 4: clk cycles per sample tick, ≥1.
- `STABLE_CNT`, 3: consecutive equal tick samples required to accept a new level, ≥1.
- `RESET_LEVEL`, 1'b0: level loaded into every channel at reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pb_in` in CHANNELS: raw asynchronous inputs.
- `pb_level` out CHANNELS: debounced level per channel.
- `pb_rise` out CHANNELS: one-cycle pulse when `pb_level[i]` goes 0→1.
- `pb_fall` out CHANNELS: one-cycle pulse when `pb_level[i]` goes 1→0.
- `pb_any` out 1: OR of all `pb_rise | pb_fall`.

## Operation
- Input stage: `pb_s` is the sampled input (see Configuration).
- Tick generator: counter 0..TICK_DIV-1, wraps. `tick` is high for one cycle when count == TICK_DIV-1. With TICK_DIV=1, `tick` is high every cycle.
- Per-channel FSM, with state and counter updated only on `tick`:
  - ST_STABLE: if `pb_s[i]` ≠ `pb_level[i]`, set cnt = 1. If cnt reaches STABLE_CNT, accept immediately; otherwise go to ST_PENDING. If equal, stay.
  - ST_PENDING: if `pb_s[i]` == `pb_level[i]` (glitch), set cnt = 0 and return to ST_STABLE. Otherwise cnt++. When cnt reaches STABLE_CNT, accept.
  - Accept: `pb_level[i]` ← `pb_s[i]`, cnt = 0, state ST_STABLE, and the matching `pb_rise[i]`/`pb_fall[i]` asserts for exactly one clk.
- Counter width is `$clog2(STABLE_CNT+1)`. It never exceeds STABLE_CNT and never wraps.
- With STABLE_CNT=1, ST_PENDING is never entered; the first differing tick sample is accepted.
- Channels are fully independent. Several channels may pulse in the same cycle. Rise and fall are never both high on one channel.

## Timing
- Reset values:
  - `pb_level` = {CHANNELS{RESET_LEVEL}}.
  - `pb_rise`, `pb_fall`, `pb_any` = 0.
  - Tick counter = 0, all FSMs ST_STABLE, all cnt = 0.
  - Synchroniser flops = RESET_LEVEL.
- First `tick` occurs on the TICK_DIV-th rising edge after `rst_n` deasserts.
- Acceptance happens on the clock edge of the STABLE_CNT-th consecutive differing tick sample. `pb_level`, `pb_rise` and `pb_fall` change on that same edge; the pulses drop on the next edge.
- Latency from a clean change of `pb_in` to `pb_level`: SYNC + (STABLE_CNT-1)·TICK_DIV + [1..TICK_DIV] cycles, where SYNC = 2 with the synchroniser, 0 without.
- `pb_any` is combinational from registered pulses, so it is cycle-aligned with them.
- Reset mid-operation: everything returns to reset values immediately (async). No pulse is emitted for a level forced by reset.

## Configuration
- `DEBOUNCE_SYNC_EN` defined: a two-flop synchroniser per channel on clk; `pb_s` is the second flop. Adds 2 cycles of latency.
- Not defined: `pb_s` = `pb_in` directly. Use only when inputs are already synchronous to clk.

## Structure
- Package `debounce_pkg` holds:
  - `typedef enum logic {ST_STABLE, ST_PENDING} db_state_t`.
  - Function `db_cnt_w(STABLE_CNT)` returning the counter width.
- Sub-module `db_tick_gen` (parameter TICK_DIV; ports clk, rst_n, tick) is the prescaler, shared as a single instance by all channels.
- Per-channel logic is built in a generate loop, not as a separate module.

## Test plan
All scenarios use CHANNELS=4, TICK_DIV=4, STABLE_CNT=3, with `DEBOUNCE_SYNC_EN` defined.
- Reset with `pb_in`=4'hF held → `pb_level`=4'h0, no pulses during reset or on the first edge after `rst_n`=1. The first acceptance of 1s occurs 11–14 cycles after release.
- Clean press: `pb_in[0]` 0→1 and held → `pb_level[0]`=1 within 11–14 cycles, with exactly one `pb_rise[0]` pulse of width 1 and `pb_any` aligned.
- Bounce: `pb_in[1]` toggles every 3 clk for 30 cycles, then holds 1 → no `pb_rise[1]` during bouncing, and exactly one pulse ≤14 cycles after settling.
- Glitch: `pb_in[2]` high for 5 cycles, then low → `pb_level[2]` stays 0 and no pulses.
- Simultaneous: `pb_level[0]`=1; drop `pb_in[0]` and raise `pb_in[3]` on the same cycle → `pb_fall[0]` and `pb_rise[3]` pulse in the same cycle, and `pb_any` high for exactly 1 cycle.
- Reset in ST_PENDING: after 2 differing ticks on channel 1, assert `rst_n`=0 → `pb_level`=0 immediately and no pulse. Rebuild without the macro → clean-press latency becomes 9–12 cycles.
